palette_lut: RTL and testbench
==============================

Name: palette_lut

Overview:
- Downstream stage of the background filler and the other pixel-index producers.
- Converts the 9-bit palette index ({palette[4:0], colour[3:0]}) into 8-bit RGB332 for the VGA DAC pins.
- Holds a 512 x 8 palette RAM. The CPU rewrites the RAM through a single-entry write buffer, and the buffer commits only during blanking so no visible pixel tears.
- Delays hsync/vsync/blank from the timing generator so they stay aligned with the coloured pixel.

Parameters:
- DEPTH_BITS, 9, palette address width (512 entries); index width equals this.
- COLOR_BITS, 8, RGB332 word width.
- PIPE_LAT, 2, index-to-RGB latency in clocks; fixed, only 2 is supported.
- WRITE_ANYTIME, 0, 1 = commit buffered writes regardless of blank; 0 = commit only while blank_in=1.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- index_in  in  9  palette index from the pixel pipeline, valid every clock.
- hsync_in  in  1  horizontal sync from the timing generator, active-low.
- vsync_in  in  1  vertical sync from the timing generator, active-low.
- blank_in  in  1  1 = outside the visible area.
- wr_req  in  1  CPU palette write request; held until acked.
- wr_addr  in  9  palette entry to write.
- wr_data  in  8  RGB332 value.
- wr_ack  out  1  one-cycle pulse: request captured.
- wr_busy  out  1  write buffer occupied.
- red  out  3  pixel red.
- green  out  3  pixel green.
- blue  out  2  pixel blue.
- hsync_out  out  1  hsync delayed by PIPE_LAT.
- vsync_out  out  1  vsync delayed by PIPE_LAT.
- blank_out  out  1  blank delayed by PIPE_LAT.

Behaviour:
- Reset (rst=0, asynchronous):
  - red/green/blue=0; hsync_out=1, vsync_out=1, blank_out=1.
  - wr_ack=0, wr_busy=0; write buffer emptied.
  - Pipeline sync/blank stages set to 1 and data stages to 0.
  - RAM contents are not cleared; they come from the init file at configuration.
  - Reset mid-write discards the buffered entry. An entry already committed to RAM stays.
- Read pipeline:
  - Cycle N: index_in sampled as the RAM read address.
  - Cycle N+1: RAM output registered; hsync/vsync/blank go into stage-1 registers.
  - Cycle N+2: output register loads the RAM data, or 0 if stage-1 blank=1; syncs/blank move to the outputs.
  - Latency is exactly 2 clocks for all outputs, with no bubbles.
- Write buffer FSM, states EMPTY and FULL:
  - EMPTY, wr_req=1: capture wr_addr/wr_data, go to FULL. Next cycle wr_ack=1 for exactly 1 cycle.
  - FULL: wr_busy=1 and wr_req is ignored; the master holds wr_req and its data stable.
  - FULL and commit condition true: RAM written that clock, state goes to EMPTY. The next request can be captured the following cycle.
  - Commit condition: blank_in=1, or WRITE_ANYTIME=1.
  - wr_req held high across a commit is recaptured as a new write only if the master has not yet seen the ack. Masters must drop wr_req on the cycle they see wr_ack.
  - Max throughput is one write per 2 clocks during blanking.
- Read/write same address, same cycle: read-first. The read returns the old data, and the new value is visible from the next read.
- Index out of range cannot occur (9-bit index, 512 entries). Upper palette bits pass straight into the address; no wrap logic.
- blank_out=1 forces RGB 0 even if the RAM holds non-zero data.

Test Plan:
- Reset then preloaded RAM:
  - Stimulus: index_in=0x005 with entry 5 = 0xE0, blank_in=0.
  - Required: red=7, green=0, blue=0 exactly 2 clocks later. Outputs are 0 and syncs are 1 during and right after reset.
- Sync alignment:
  - Stimulus: one-cycle hsync_in low pulse at cycle 10; index ramps 0..15.
  - Required: hsync_out low at cycle 12 only, coincident with the colour of the cycle-10 index.
- Write held until blank:
  - Stimulus: wr_req with addr 0x007, data 0x1C while blank_in=0 (WRITE_ANYTIME=0).
  - Required: wr_ack pulse, wr_busy=1 and held. No change on index 7 reads until blank_in rises. The commit happens in that cycle and reads of 7 after blank return 0x1C (green=7).
- Back-to-back writes:
  - Stimulus: two requests during blanking.
  - Required: second ack no earlier than 2 clocks after the first; both entries hold the correct data.
- Read-first collision:
  - Stimulus: commit to 0x012 in the same cycle index_in=0x012 (WRITE_ANYTIME=1).
  - Required: that pixel shows the old value; the next cycle's read shows the new value.
- Async reset mid-operation:
  - Stimulus: assert rst low between clock edges while FULL.
  - Required: wr_busy drops immediately without waiting for a clock edge; the RAM entry is unchanged after release.

Source files
------------

// File: rtl/palette_lut.sv
// Palette lookup: 9-bit index to RGB332 with a blank-gated CPU write buffer.
// Sync/blank are delayed to stay aligned with the coloured pixel.
module palette_lut #(
  parameter int DEPTH_BITS    = 9,
  parameter int COLOR_BITS    = 8,
  parameter int PIPE_LAT      = 2,
  parameter int WRITE_ANYTIME = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_BITS-1:0] index_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  blank_in,
  input  logic                  wr_req,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [COLOR_BITS-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  wr_busy,
  output logic [2:0]            red,
  output logic [2:0]            green,
  output logic [1:0]            blue,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  blank_out
);

  typedef enum logic {EMPTY, FULL} wb_state_t;

  logic [COLOR_BITS-1:0] mem [0:(1<<DEPTH_BITS)-1];

  wb_state_t             state_q, state_d;
  logic [DEPTH_BITS-1:0] addr_q, addr_d;
  logic [COLOR_BITS-1:0] data_q, data_d;
  logic                  ack_q, ack_d;
  logic [COLOR_BITS-1:0] rd_q, rd_d;
  logic [COLOR_BITS-1:0] rgb_q, rgb_d;
  logic [2:0]            sync_q [PIPE_LAT];
  logic [2:0]            sync_d [PIPE_LAT];
  logic                  commit;

  assign commit = (state_q == FULL) &&
                  (blank_in || (WRITE_ANYTIME != 0));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (wr_req) begin
          state_d = FULL;
          addr_d  = wr_addr;
          data_d  = wr_data;
          ack_d   = 1'b1;
        end
      end
      FULL: begin
        if (commit) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Read-first: the read samples RAM before this edge's commit lands.
  always_comb begin
    rd_d = mem[index_in];
    sync_d[0] = {hsync_in, vsync_in, blank_in};
    for (int i = 1; i < PIPE_LAT; i++) sync_d[i] = sync_q[i-1];
    rgb_d = sync_q[PIPE_LAT-2][0] ? '0 : rd_q;
  end

  always_ff @(posedge clk) begin
    if (commit) mem[addr_q] <= data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
      rgb_q   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) sync_q[i] <= '1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      rgb_q   <= rgb_d;
      for (int i = 0; i < PIPE_LAT; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign wr_ack  = ack_q;
  assign wr_busy = (state_q == FULL);
  assign {red, green, blue} = rgb_q;
  assign hsync_out = sync_q[PIPE_LAT-1][2];
  assign vsync_out = sync_q[PIPE_LAT-1][1];
  assign blank_out = sync_q[PIPE_LAT-1][0];

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: two instances (commit-in-blank and
// commit-anytime) checked through an expected-result queue.
module tb_palette_lut;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] index_in = '0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       blank_in = 1'b1;

  logic       a_wr_req = 1'b0;
  logic [8:0] a_wr_addr = '0;
  logic [7:0] a_wr_data = '0;
  logic       a_wr_ack, a_wr_busy;
  logic [2:0] a_red, a_green;
  logic [1:0] a_blue;
  logic       a_hs, a_vs, a_bl;

  logic       b_wr_req = 1'b0;
  logic [8:0] b_wr_addr = '0;
  logic [7:0] b_wr_data = '0;
  logic       b_wr_ack, b_wr_busy;
  logic [2:0] b_red, b_green;
  logic [1:0] b_blue;
  logic       b_hs, b_vs, b_bl;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  typedef struct {
    bit         sel;
    bit         rc;
    logic [7:0] rgb;
    logic [2:0] syn;
    int         due;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  palette_lut #(.WRITE_ANYTIME(0)) u_a (
    .clk(clk), .rst(rst), .index_in(index_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_ack(a_wr_ack), .wr_busy(a_wr_busy),
    .red(a_red), .green(a_green), .blue(a_blue),
    .hsync_out(a_hs), .vsync_out(a_vs), .blank_out(a_bl)
  );

  palette_lut #(.WRITE_ANYTIME(1)) u_b (
    .clk(clk), .rst(rst), .index_in(index_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_ack(b_wr_ack), .wr_busy(b_wr_busy),
    .red(b_red), .green(b_green), .blue(b_blue),
    .hsync_out(b_hs), .vsync_out(b_vs), .blank_out(b_bl)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    logic [7:0] orgb;
    logic [2:0] osyn;
    @(posedge clk);
    #1;
    cycle++;
    while (sbq.size() > 0 && sbq[0].due <= cycle) begin
      e = sbq.pop_front();
      orgb = e.sel ? {b_red, b_green, b_blue} : {a_red, a_green, a_blue};
      osyn = e.sel ? {b_hs, b_vs, b_bl} : {a_hs, a_vs, a_bl};
      if (e.rc) chk({e.tag, "_rgb"}, {24'd0, orgb}, {24'd0, e.rgb});
      chk({e.tag, "_syn"}, {29'd0, osyn}, {29'd0, e.syn});
    end
  endtask

  task automatic px(bit sel, logic [8:0] idx, logic hs, logic vs,
                    logic bl, bit rc, logic [7:0] rgb, string tag);
    exp_t e;
    index_in = idx;
    hsync_in = hs;
    vsync_in = vs;
    blank_in = bl;
    e.sel = sel;
    e.rc  = rc;
    e.rgb = rgb;
    e.syn = {hs, vs, bl};
    e.due = cycle + 2;
    e.tag = tag;
    sbq.push_back(e);
    cyc();
  endtask

  task automatic wr(bit sel, logic [8:0] a, logic [7:0] d,
                    string tag, output int ackc);
    ackc = -1;
    if (sel) begin
      b_wr_req = 1'b1; b_wr_addr = a; b_wr_data = d;
    end else begin
      a_wr_req = 1'b1; a_wr_addr = a; a_wr_data = d;
    end
    for (int n = 0; n < 20; n++) begin
      cyc();
      if ((sel ? b_wr_ack : a_wr_ack) === 1'b1) begin
        ackc = cycle;
        break;
      end
    end
    a_wr_req = 1'b0;
    b_wr_req = 1'b0;
    chk({tag, "_acked"}, {31'd0, ackc >= 0}, 32'd1);
    chk({tag, "_busy"}, {31'd0, sel ? b_wr_busy : a_wr_busy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c;

    // Power-on reset values.
    cyc();
    chk("rst_rgb", {24'd0, a_red, a_green, a_blue}, 32'd0);
    chk("rst_syn", {29'd0, a_hs, a_vs, a_bl}, 32'd7);
    chk("rst_ack", {31'd0, a_wr_ack}, 32'd0);
    chk("rst_busy", {31'd0, a_wr_busy}, 32'd0);
    chk("rst_b_syn", {29'd0, b_hs, b_vs, b_bl}, 32'd7);
    rst = 1'b1;

    // Preload palette entries during blanking.
    blank_in = 1'b1;
    wr(0, 9'h005, 8'hE0, "pre5", c);  cyc();
    wr(0, 9'h007, 8'h03, "pre7", c);  cyc();
    wr(0, 9'h00A, 8'h92, "pre10", c); cyc();
    wr(1, 9'h012, 8'h49, "preb12", c); cyc();

    // Reset again: RAM must survive, outputs return to idle.
    #2 rst = 1'b0;
    #1;
    chk("rst2_rgb", {24'd0, a_red, a_green, a_blue}, 32'd0);
    chk("rst2_syn", {29'd0, a_hs, a_vs, a_bl}, 32'd7);
    cyc();
    chk("rst2_hold_syn", {29'd0, a_hs, a_vs, a_bl}, 32'd7);
    rst = 1'b1;
    px(0, 9'h000, 1, 1, 1, 1, 8'h00, "post_rst");
    px(0, 9'h005, 1, 1, 0, 1, 8'hE0, "pre_read5");
    px(0, 9'h005, 1, 1, 0, 1, 8'hE0, "pre_read5b");

    // Index ramp with one hsync pulse on index 10.
    for (int i = 0; i < 16; i++) begin
      logic [8:0] ix;
      logic [7:0] ev;
      bit kn;
      ix = 9'(i);
      kn = (i == 5) || (i == 7) || (i == 10);
      ev = (i == 5) ? 8'hE0 : (i == 7) ? 8'h03 : 8'h92;
      px(0, ix, (i == 10) ? 1'b0 : 1'b1, 1, 0, kn, ev, "ramp");
    end
    cyc(); cyc();

    // Write held in the buffer until blank rises.
    blank_in = 1'b0;
    wr(0, 9'h007, 8'h1C, "hold", c);
    px(0, 9'h007, 1, 1, 0, 1, 8'h03, "hold_old");
    chk("hold_ack_pulse", {31'd0, a_wr_ack}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      px(0, 9'h007, 1, 1, 0, 1, 8'h03, "hold_old");
      chk("hold_busy", {31'd0, a_wr_busy}, 32'd1);
    end
    px(0, 9'h007, 1, 1, 1, 1, 8'h00, "hold_blank");
    chk("hold_commit_busy", {31'd0, a_wr_busy}, 32'd0);
    px(0, 9'h007, 1, 1, 0, 1, 8'h1C, "hold_new");
    px(0, 9'h007, 1, 1, 0, 1, 8'h1C, "hold_new");
    cyc(); cyc();

    // Back-to-back writes during blanking.
    blank_in = 1'b1;
    wr(0, 9'h020, 8'h55, "b2b1", c1);
    wr(0, 9'h021, 8'hAA, "b2b2", c2);
    chk("b2b_spacing", {31'd0, (c2 - c1) >= 2}, 32'd1);
    cyc();
    px(0, 9'h020, 1, 1, 0, 1, 8'h55, "b2b_rd20");
    px(0, 9'h021, 1, 1, 0, 1, 8'hAA, "b2b_rd21");
    px(0, 9'h005, 1, 1, 0, 1, 8'hE0, "b2b_rd5");
    cyc(); cyc();

    // Read-first collision on the commit-anytime instance.
    blank_in = 1'b0;
    b_wr_req = 1'b1; b_wr_addr = 9'h012; b_wr_data = 8'hB6;
    cyc();
    chk("col_ack", {31'd0, b_wr_ack}, 32'd1);
    b_wr_req = 1'b0;
    px(1, 9'h012, 1, 1, 0, 1, 8'h49, "col_old");
    px(1, 9'h012, 1, 1, 0, 1, 8'hB6, "col_new");
    cyc(); cyc();

    // Asynchronous reset while the buffer is full.
    blank_in = 1'b0;
    wr(0, 9'h005, 8'h00, "arst", c);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, a_wr_busy}, 32'd0);
    chk("arst_ack", {31'd0, a_wr_ack}, 32'd0);
    cyc();
    rst = 1'b1;
    px(0, 9'h005, 1, 1, 1, 1, 8'h00, "arst_blank");
    px(0, 9'h005, 1, 1, 1, 1, 8'h00, "arst_blank");
    px(0, 9'h005, 1, 1, 0, 1, 8'hE0, "arst_keep");
    cyc(); cyc();
    chk("sb_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
